// File: rtl/sram_ctrl_multibeat_if.sv
// CPU-side request/response bundle of the multi-beat SRAM controller.
// The MEM stage drives the request side; the controller answers with data, stall and completion.
interface sram_ctrl_multibeat_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 18
);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] data_out;
   logic              freeze;
   logic              done;

   modport master (
      output mem_read, mem_write, address, data,
      input  data_out, freeze, done
   );

   modport slave (
      input  mem_read, mem_write, address, data,
      output data_out, freeze, done
   );
endinterface

// File: rtl/sram_ctrl_multibeat.sv
// Splits one DATA_W-bit CPU access into DATA_W/DQ_W consecutive async-SRAM beats of
// ACCESS_CYCLES clocks each; all SRAM strobes, address and write data are registered.
module sram_ctrl_multibeat #(
   parameter int DATA_W        = 32,
   parameter int DQ_W          = 16,
   parameter int ADDR_W        = 18,
   parameter int ACCESS_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst,
   sram_ctrl_multibeat_if.slave cpu,
   output logic [ADDR_W-1:0]  SRAM_ADDR,
   inout  wire  [DQ_W-1:0]    SRAM_DQ,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N
);

   localparam int BEATS = DATA_W / DQ_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = $clog2(ACCESS_CYCLES);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_CYC  = CW'(ACCESS_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
   logic [DATA_W-1:0] data_lat_q, data_lat_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              ce_n_q, ce_n_d;
   logic              dq_oe_q, dq_oe_d;
   logic [DQ_W-1:0]   dq_out_q, dq_out_d;
   logic              req;

   assign req = cpu.mem_read | cpu.mem_write;

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      cyc_d       = cyc_q;
      wr_d        = wr_q;
      addr_lat_d  = addr_lat_q;
      data_lat_d  = data_lat_q;
      data_out_d  = data_out_q;
      sram_addr_d = sram_addr_q;
      we_n_d      = we_n_q;
      oe_n_d      = oe_n_q;
      ce_n_d      = ce_n_q;
      dq_oe_d     = dq_oe_q;
      dq_out_d    = dq_out_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               // Write wins a simultaneous read; beat 0 outputs go live on this edge.
               state_d     = ST_ACCESS;
               beat_d      = '0;
               cyc_d       = '0;
               wr_d        = cpu.mem_write;
               addr_lat_d  = cpu.address;
               data_lat_d  = cpu.data;
               sram_addr_d = cpu.address;
               ce_n_d      = 1'b0;
               oe_n_d      = cpu.mem_write;
               we_n_d      = ~cpu.mem_write;
               dq_oe_d     = cpu.mem_write;
               dq_out_d    = cpu.data[DQ_W-1:0];
            end
         end
         ST_ACCESS: begin
            if (!req) begin
               state_d = ST_IDLE;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               ce_n_d  = 1'b1;
               dq_oe_d = 1'b0;
            end else if (cyc_q == LAST_CYC) begin
               if (!wr_q)
                  data_out_d[int'(beat_q)*DQ_W +: DQ_W] = SRAM_DQ;
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_DONE;
                  we_n_d  = 1'b1;
                  oe_n_d  = 1'b1;
                  ce_n_d  = 1'b1;
                  dq_oe_d = 1'b0;
               end else begin
                  beat_d      = beat_q + 1'b1;
                  cyc_d       = '0;
                  sram_addr_d = addr_lat_q + ADDR_W'(beat_d);
                  we_n_d      = ~wr_q;
                  dq_out_d    = data_lat_q[int'(beat_d)*DQ_W +: DQ_W];
               end
            end else begin
               // WE_N returns high for the final cycle of each beat so data is held past its rising edge.
               cyc_d  = cyc_q + 1'b1;
               we_n_d = wr_q ? (cyc_d == LAST_CYC) : 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         cyc_q       <= '0;
         wr_q        <= 1'b0;
         data_out_q  <= '0;
         sram_addr_q <= '0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         ce_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         cyc_q       <= cyc_d;
         wr_q        <= wr_d;
         data_out_q  <= data_out_d;
         sram_addr_q <= sram_addr_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         ce_n_q      <= ce_n_d;
         dq_oe_q     <= dq_oe_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_lat_q <= addr_lat_d;
      data_lat_q <= data_lat_d;
      dq_out_q   <= dq_out_d;
   end

   assign SRAM_DQ      = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};
   assign SRAM_ADDR    = sram_addr_q;
   assign SRAM_WE_N    = we_n_q;
   assign SRAM_OE_N    = oe_n_q;
   assign SRAM_CE_N    = ce_n_q;
   assign cpu.data_out = data_out_q;
   assign cpu.done     = (state_q == ST_DONE);
   assign cpu.freeze   = req && (state_q != ST_DONE);

endmodule

// File: tb/tb_sram_ctrl_multibeat.sv
// Directed bench for sram_ctrl_multibeat: a 32/16-bit, 3-cycle instance and a 64/16-bit,
// 2-cycle instance, each attached to a small async-SRAM model.
module tb_sram_ctrl_multibeat;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   sram_ctrl_multibeat_if #(.DATA_W(32), .ADDR_W(18)) if_a ();
   sram_ctrl_multibeat_if #(.DATA_W(64), .ADDR_W(18)) if_b ();

   wire  [15:0] dq_a, dq_b;
   logic [17:0] addr_a, addr_b;
   logic        we_a, oe_a, ce_a, we_b, oe_b, ce_b;

   sram_ctrl_multibeat #(.DATA_W(32), .DQ_W(16), .ADDR_W(18), .ACCESS_CYCLES(3)) dut_a (
      .clk(clk), .rst(rst_a), .cpu(if_a), .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a),
      .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a), .SRAM_CE_N(ce_a));

   sram_ctrl_multibeat #(.DATA_W(64), .DQ_W(16), .ADDR_W(18), .ACCESS_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst_b), .cpu(if_b), .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b),
      .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b), .SRAM_CE_N(ce_b));

   // SRAM models: drive on read, commit a word when WE_N rises while CE_N is still low.
   logic [15:0] mem_a [0:262143];
   logic [15:0] mem_b [0:262143];
   logic        we_prev_a = 1'b1, we_prev_b = 1'b1;

   assign dq_a = (!ce_a && !oe_a && we_a) ? mem_a[addr_a] : 16'bz;
   assign dq_b = (!ce_b && !oe_b && we_b) ? mem_b[addr_b] : 16'bz;

   always @(negedge clk) begin
      if (we_prev_a == 1'b0 && we_a == 1'b1 && ce_a == 1'b0) mem_a[addr_a] <= dq_a;
      if (we_prev_b == 1'b0 && we_b == 1'b1 && ce_b == 1'b0) mem_b[addr_b] <= dq_b;
      we_prev_a <= we_a;
      we_prev_b <= we_b;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full request; returns freeze length, completion, read data and strobe traces.
   task automatic run_txn(input int sel, input bit rd, input bit wr, input logic [17:0] a,
                          input logic [63:0] d, output int fcnt, output bit got,
                          output logic [63:0] dout, output logic [15:0] we_tr,
                          output logic [17:0] addr4, output int bad);
      logic f_, dn_, we_, oe_, ce_;
      logic [17:0] ad_;
      fcnt = 0; got = 1'b0; dout = '0; we_tr = '0; addr4 = '0; bad = 0;
      @(negedge clk);
      if (sel == 0) begin
         if_a.mem_read = rd; if_a.mem_write = wr; if_a.address = a; if_a.data = d[31:0];
      end else begin
         if_b.mem_read = rd; if_b.mem_write = wr; if_b.address = a; if_b.data = d;
      end
      for (int k = 0; k < 40; k++) begin
         #1;
         if (sel == 0) begin
            f_ = if_a.freeze; dn_ = if_a.done; we_ = we_a; oe_ = oe_a; ce_ = ce_a; ad_ = addr_a;
            dout = 64'(if_a.data_out);
         end else begin
            f_ = if_b.freeze; dn_ = if_b.done; we_ = we_b; oe_ = oe_b; ce_ = ce_b; ad_ = addr_b;
            dout = if_b.data_out;
         end
         if (dn_) begin
            got = 1'b1;
            break;
         end
         if (f_) fcnt++;
         if (k >= 1) begin
            we_tr = {we_tr[14:0], we_};
            if (k == 4) addr4 = ad_;
            if (wr && (oe_ !== 1'b1 || ce_ !== 1'b0)) bad++;
            if (!wr && (we_ !== 1'b1 || oe_ !== 1'b0 || ce_ !== 1'b0)) bad++;
         end
         @(negedge clk);
      end
      if (sel == 0) begin
         if_a.mem_read = 1'b0; if_a.mem_write = 1'b0;
      end else begin
         if_b.mem_read = 1'b0; if_b.mem_write = 1'b0;
      end
      @(negedge clk);
   endtask

   int          fc, bd;
   bit          gd;
   logic [63:0] dout;
   logic [15:0] wtr;
   logic [17:0] a4;

   initial begin
      if_a.mem_read = 1'b0; if_a.mem_write = 1'b0; if_a.address = '0; if_a.data = '0;
      if_b.mem_read = 1'b0; if_b.mem_write = 1'b0; if_b.address = '0; if_b.data = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      check("rst_data_out", 64'(if_a.data_out), 64'h0);
      check("rst_sram_addr", 64'(addr_a), 64'h0);
      check("rst_done", 64'(if_a.done), 64'h0);
      check("rst_freeze", 64'(if_a.freeze), 64'h0);
      check("rst_strobes", 64'({we_a, oe_a, ce_a}), 64'b111);
      check("rst_b_data_out", if_b.data_out, 64'h0);

      // Write 0xDEADBEEF at 0x10
      run_txn(0, 1'b0, 1'b1, 18'h00010, 64'hDEADBEEF, fc, gd, dout, wtr, a4, bd);
      check("wr_freeze_cycles", 64'(fc), 64'd7);
      check("wr_done", 64'(gd), 64'd1);
      check("wr_mem_lo", 64'(mem_a[18'h10]), 64'hBEEF);
      check("wr_mem_hi", 64'(mem_a[18'h11]), 64'hDEAD);
      check("wr_oe_high", 64'(bd), 64'd0);
      check("wr_we_pattern", 64'(wtr[5:0]), 64'b001001);

      // Read it back
      run_txn(0, 1'b1, 1'b0, 18'h00010, 64'h0, fc, gd, dout, wtr, a4, bd);
      check("rd_freeze_cycles", 64'(fc), 64'd7);
      check("rd_done", 64'(gd), 64'd1);
      check("rd_data", dout, 64'hDEADBEEF);
      check("rd_strobes", 64'(bd), 64'd0);

      // Address wrap
      run_txn(0, 1'b0, 1'b1, 18'h3FFFF, 64'hA5A55A5A, fc, gd, dout, wtr, a4, bd);
      check("wrap_beat1_addr", 64'(a4), 64'h0);
      check("wrap_we_pattern", 64'(wtr[5:0]), 64'b001001);
      check("wrap_mem_top", 64'(mem_a[18'h3FFFF]), 64'h5A5A);
      check("wrap_mem_zero", 64'(mem_a[18'h0]), 64'hA5A5);

      // Read and write together: write wins
      run_txn(0, 1'b1, 1'b1, 18'h00040, 64'h12345678, fc, gd, dout, wtr, a4, bd);
      check("rw_done", 64'(gd), 64'd1);
      check("rw_data_out_kept", dout, 64'hDEADBEEF);
      check("rw_mem_lo", 64'(mem_a[18'h40]), 64'h5678);
      check("rw_mem_hi", 64'(mem_a[18'h41]), 64'h1234);

      // Abort: prefill 0x20/0x21, then drop the write after three ACCESS cycles
      run_txn(0, 1'b0, 1'b1, 18'h00020, 64'h11112222, fc, gd, dout, wtr, a4, bd);
      @(negedge clk);
      if_a.mem_write = 1'b1; if_a.address = 18'h00020; if_a.data = 32'hCAFEF00D;
      @(negedge clk);
      if_a.address = 18'h00030; if_a.data = 32'h0;
      repeat (2) @(negedge clk);
      if_a.mem_write = 1'b0;
      @(negedge clk);
      #1;
      check("abort_strobes", 64'({we_a, oe_a, ce_a}), 64'b111);
      check("abort_done", 64'(if_a.done), 64'h0);
      check("abort_mem_beat0", 64'(mem_a[18'h20]), 64'hF00D);
      check("abort_mem_beat1", 64'(mem_a[18'h21]), 64'h1111);
      @(negedge clk);
      #1;
      check("abort_done_later", 64'(if_a.done), 64'h0);

      // 64-bit, 2-cycle instance
      run_txn(1, 1'b0, 1'b1, 18'h00100, 64'h0123456789ABCDEF, fc, gd, dout, wtr, a4, bd);
      check("b_wr_freeze_cycles", 64'(fc), 64'd9);
      check("b_wr_mem3", 64'(mem_b[18'h103]), 64'h0123);
      run_txn(1, 1'b1, 1'b0, 18'h00100, 64'h0, fc, gd, dout, wtr, a4, bd);
      check("b_rd_freeze_cycles", 64'(fc), 64'd9);
      check("b_rd_done", 64'(gd), 64'd1);
      check("b_rd_data", dout, 64'h0123456789ABCDEF);

      // Reset in the middle of a read
      @(negedge clk);
      if_b.mem_read = 1'b1; if_b.address = 18'h00100;
      repeat (3) @(negedge clk);
      rst_b = 1'b1; if_b.mem_read = 1'b0;
      @(negedge clk);
      #1;
      check("b_rst_strobes", 64'({we_b, oe_b, ce_b}), 64'b111);
      check("b_rst_data_out", if_b.data_out, 64'h0);
      check("b_rst_done", 64'(if_b.done), 64'h0);
      rst_b = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
